// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter stages: FSM encoding, accumulator
// sizing and Q-format helpers used by both iir_ff and iir_fb.
package iir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  localparam int PRECISION_DEF   = 16;
  localparam int TAPS_DEF        = 4;
  localparam int COEFF_WIDTH_DEF = 16;
  localparam int FRAC_BITS_DEF   = 14;

  // Q-format unity and half-LSB for the default fractional width.
  localparam int ONE  = 1 << FRAC_BITS_DEF;
  localparam int HALF = 1 << (FRAC_BITS_DEF - 1);

  // Sized so that TAPS full-scale products can be summed without wrapping.
  function automatic int acc_width(input int precision, input int coeff_width,
                                   input int taps);
    return precision + coeff_width + $clog2(taps);
  endfunction

  function automatic int q_one(input int frac_bits);
    return 1 << frac_bits;
  endfunction

endpackage

// File: rtl/iir_ff_if.sv
// Sample/coefficient/result bundle of the feed-forward stage.
interface iir_ff_if #(
  parameter int PRECISION   = iir_pkg::PRECISION_DEF,
  parameter int TAPS        = iir_pkg::TAPS_DEF,
  parameter int COEFF_WIDTH = iir_pkg::COEFF_WIDTH_DEF
);
  localparam int ADDR_W = $clog2(TAPS);

  logic                          x_valid;
  logic signed [PRECISION-1:0]   x;
  logic                          coeff_we;
  logic        [ADDR_W-1:0]      coeff_addr;
  logic signed [COEFF_WIDTH-1:0] coeff_data;
  logic                          busy;
  logic signed [PRECISION-1:0]   y;
  logic                          y_valid;
  logic                          overrun;

  modport master (
    output x_valid, x, coeff_we, coeff_addr, coeff_data,
    input  busy, y, y_valid, overrun
  );

  modport slave (
    input  x_valid, x, coeff_we, coeff_addr, coeff_data,
    output busy, y, y_valid, overrun
  );

endinterface

// File: rtl/iir_round_sat.sv
// Round-half-up then saturate an accumulator value down to PRECISION bits,
// dropping FRAC_BITS of coefficient fraction.
module iir_round_sat #(
  parameter int ACC_W     = 34,
  parameter int PRECISION = 16,
  parameter int FRAC_BITS = 14
) (
  input  logic signed [ACC_W-1:0]     acc_i,
  output logic signed [PRECISION-1:0] y_o
);

  // One guard bit so adding the half LSB can never wrap.
  localparam int SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] HALF_LSB = SUM_W'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [SUM_W-1:0] Y_MAX    = SUM_W'((64'sd1 <<< (PRECISION - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] Y_MIN    = -Y_MAX - SUM_W'(1);

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shifted;

  always_comb begin
    sum     = SUM_W'(acc_i) + HALF_LSB;
    shifted = sum >>> FRAC_BITS;
    if (shifted > Y_MAX) begin
      y_o = Y_MAX[PRECISION-1:0];
    end else if (shifted < Y_MIN) begin
      y_o = Y_MIN[PRECISION-1:0];
    end else begin
      y_o = shifted[PRECISION-1:0];
    end
  end

endmodule

// File: rtl/iir_ff.sv
// Feed-forward (numerator) IIR stage: TAPS-deep delay line, one shared
// multiplier stepping through the taps, rounded/saturated registered output.
module iir_ff
  import iir_pkg::*;
#(
  parameter int PRECISION   = PRECISION_DEF,
  parameter int TAPS        = TAPS_DEF,
  parameter int COEFF_WIDTH = COEFF_WIDTH_DEF,
  parameter int FRAC_BITS   = FRAC_BITS_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  iir_ff_if.slave  bus
);

  localparam int ACC_W  = acc_width(PRECISION, COEFF_WIDTH, TAPS);
  localparam int IDX_W  = $clog2(TAPS);
  localparam int PROD_W = PRECISION + COEFF_WIDTH;
  localparam logic [IDX_W-1:0]             LAST_IDX  = IDX_W'(TAPS - 1);
  localparam logic signed [COEFF_WIDTH-1:0] COEFF_ONE = COEFF_WIDTH'(q_one(FRAC_BITS));

  state_e state_q, state_d;

  logic signed [PRECISION-1:0]   dly_q  [TAPS];
  logic signed [COEFF_WIDTH-1:0] coef_q [TAPS];
  logic        [IDX_W-1:0]       idx_q;
  logic signed [ACC_W-1:0]       acc_q;
  logic signed [PRECISION-1:0]   y_q;
  logic                          y_valid_q;
  logic                          overrun_q;

  logic                          busy;
  logic                          accept;
  logic                          coeff_wr;
  logic signed [PROD_W-1:0]      prod;
  logic signed [PRECISION-1:0]   y_sat;

  assign busy     = (state_q != ST_IDLE);
  assign accept   = bus.x_valid && !busy;
  assign coeff_wr = bus.coeff_we && !busy && (int'(bus.coeff_addr) < TAPS);
  assign prod     = coef_q[idx_q] * dly_q[idx_q];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: defaulting state_d first keeps every path assigned, so no latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_MAC;
      ST_MAC:  if (idx_q == LAST_IDX) state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = busy;
    bus.y       = y_q;
    bus.y_valid = y_valid_q;
    bus.overrun = overrun_q;
  end

  // NOTE: the coefficient bank and delay line are reset like any other state;
  // a reset must restore the identity filter and an empty history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        dly_q[k]  <= '0;
        coef_q[k] <= (k == 0) ? COEFF_ONE : '0;
      end
      idx_q     <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      if (bus.x_valid && busy) overrun_q <= 1'b1;
      if (coeff_wr) coef_q[bus.coeff_addr] <= bus.coeff_data;

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            dly_q[0] <= bus.x;
            for (int k = 1; k < TAPS; k++) dly_q[k] <= dly_q[k-1];
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        ST_MAC: begin
          acc_q <= acc_q + ACC_W'(prod);
          if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
        end
        ST_OUT: begin
          y_q       <= y_sat;
          y_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  iir_round_sat #(
    .ACC_W     (ACC_W),
    .PRECISION (PRECISION),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_sat (
    .acc_i (acc_q),
    .y_o   (y_sat)
  );

endmodule

// File: tb/tb_iir_ff.sv
// Directed bench for iir_ff with TAPS=4, FRAC_BITS=14, PRECISION=16:
// identity, moving average, saturation, rounding, overrun/lockout, reset abort.
module tb_iir_ff;
  import iir_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  iir_ff_if bus ();

  iir_ff dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    bus.x_valid    = 1'b0;
    bus.coeff_we   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr_coef(input int addr, input int data);
    @(negedge clk);
    bus.coeff_we   = 1'b1;
    bus.coeff_addr = 2'(addr);
    bus.coeff_data = 16'(data);
    @(negedge clk);
    bus.coeff_we = 1'b0;
  endtask

  // Sends one sample and checks result, latency, busy length and hold.
  task automatic sample(input string tag, input int xv, input int exp);
    int lat;
    int busy_n;
    lat    = 0;
    busy_n = 0;
    @(negedge clk);
    bus.x_valid = 1'b1;
    bus.x       = 16'(xv);
    @(negedge clk);
    bus.x_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (bus.busy) busy_n++;
      if (bus.y_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check({tag, " latency"}, lat, 6);
    check({tag, " busy_cycles"}, busy_n, 5);
    check({tag, " y"}, bus.y, exp);
    @(negedge clk);
    check({tag, " y_valid_pulse"}, bus.y_valid, 0);
    check({tag, " y_hold"}, bus.y, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int vcount;
    int vy;

    rst_n          = 1'b0;
    bus.x_valid    = 1'b0;
    bus.x          = '0;
    bus.coeff_we   = 1'b0;
    bus.coeff_addr = '0;
    bus.coeff_data = '0;
    do_reset();
    @(negedge clk);
    check("reset y", bus.y, 0);
    check("reset y_valid", bus.y_valid, 0);
    check("reset busy", bus.busy, 0);
    check("reset overrun", bus.overrun, 0);

    sample("identity", 1000, 1000);

    // Moving average: impulse walks through all four taps.
    do_reset();
    for (int k = 0; k < 4; k++) wr_coef(k, 4096);
    sample("mavg0", 16384, 4096);
    sample("mavg1", 0, 4096);
    sample("mavg2", 0, 4096);
    sample("mavg3", 0, 4096);
    sample("mavg4", 0, 0);

    do_reset();
    wr_coef(1, 16384);
    sample("sat_pos0", 30000, 30000);
    sample("sat_pos1", 30000, 32767);
    do_reset();
    wr_coef(1, 16384);
    sample("sat_neg0", -30000, -30000);
    sample("sat_neg1", -30000, -32768);

    do_reset();
    wr_coef(0, 8192);
    sample("round_p3", 3, 2);
    sample("round_m3", -3, -1);
    sample("round_p1", 1, 1);

    // Overrun: second sample two cycles after accept, then a locked-out write.
    do_reset();
    @(negedge clk);
    bus.x_valid = 1'b1;
    bus.x       = 16'sd700;
    @(negedge clk);
    bus.x_valid = 1'b0;
    check("overrun_before", bus.overrun, 0);
    @(negedge clk);
    bus.x_valid = 1'b1;
    bus.x       = 16'sd999;
    @(negedge clk);
    bus.x_valid    = 1'b0;
    check("overrun_rise", bus.overrun, 1);
    bus.coeff_we   = 1'b1;
    bus.coeff_addr = 2'd0;
    bus.coeff_data = 16'sd0;
    @(negedge clk);
    bus.coeff_we = 1'b0;
    vcount = 0;
    vy     = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.y_valid) begin
        vcount++;
        vy = bus.y;
      end
      @(negedge clk);
    end
    check("overrun y_valid_count", vcount, 1);
    check("overrun y", vy, 700);
    check("overrun sticky", bus.overrun, 1);
    sample("lockout", 1234, 1234);

    // Reset during MAC aborts the computation.
    @(negedge clk);
    bus.x_valid = 1'b1;
    bus.x       = 16'sd321;
    @(negedge clk);
    bus.x_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.y_valid) vcount++;
      @(negedge clk);
    end
    check("abort y_valid_count", vcount, 0);
    check("abort y", bus.y, 0);
    check("abort overrun", bus.overrun, 0);
    check("abort busy", bus.busy, 0);
    sample("abort_next", 500, 500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
